// File: rtl/recir_arbiter_pkg.sv
// Shared definitions for the recirculation arbiter: FSM state encoding and default data width.
package recir_arbiter_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    RECIR = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/recir_fifo.sv
// Circular buffer for words returned on the retorno path; sticky overflow on a dropped push.
module recir_fifo
  import recir_arbiter_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          empty_next,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  // A pop frees the head slot first, so a push is still taken when full.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign empty_next = (count_next == '0);
  assign dout       = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (push & ~do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/recir_arbiter.sv
// Merges new data and buffered retorno words into one registered output; drops 'active'
// under backpressure so upstream recirculates, then drains the buffer with priority.
module recir_arbiter
  import recir_arbiter_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          enable,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  output logic          in_ready,
  input  logic [DW-1:0] data_retorno,
  input  logic          valid_retorno,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  input  logic          out_ready,
  output logic          active,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          overflow
);

  state_t        state;
  state_t        next_state;
  logic          load_en;
  logic          pop;
  logic          take_in;
  logic          empty_next;
  logic [DW-1:0] fifo_dout;

  recir_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_L    (reset_L),
    .push       (valid_retorno),
    .pop        (pop),
    .din        (data_retorno),
    .dout       (fifo_dout),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .empty_next (empty_next),
    .overflow   (overflow)
  );

  always_comb begin
    load_en    = ~valid_out | out_ready;
    pop        = load_en & ((state == PASS) | (state == DRAIN)) & ~fifo_empty;
    in_ready   = (state == PASS) & load_en & fifo_empty;
    take_in    = valid_in & in_ready;
    next_state = state;
    case (state)
      IDLE:  if (enable) next_state = PASS;
      PASS: begin
        if (valid_out & ~out_ready)  next_state = RECIR;
        else if (~enable & load_en)  next_state = IDLE;
      end
      RECIR: if (out_ready) next_state = DRAIN;
      DRAIN: begin
        if (valid_out & ~out_ready) next_state = RECIR;
        else if (empty_next)        next_state = PASS;
      end
      default: next_state = IDLE;
    endcase
  end

  // When the output slot frees and nothing qualifies to load, valid_out drops;
  // this also covers RECIR/IDLE, where the held word leaves without a successor.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      active    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state  <= next_state;
      active <= (next_state == PASS);
      if (load_en) begin
        if (pop) begin
          data_out  <= fifo_dout;
          valid_out <= 1'b1;
        end else if (take_in) begin
          data_out  <= data_in;
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end
    end
  end

endmodule
